reg_wr_arbiter: RTL and testbench
=================================

// Module: reg_wr_arbiter
//
// PURPOSE
//   Round-robin write-port arbiter for a shared WIDTH-bit enable-gated register.
//   Up to NREQ requesters compete for the write port. The arbiter drives the
//   register's writeEn/inData: at most one write per cycle, and fairness is
//   preserved under sustained contention.
//   Sits between requester logic (e.g. control/status sources) and the register instance.
//
// PARAMETERS
//   NREQ       4   number of requesters (>=2)
//   WIDTH      4   data width of shared register
//   MAX_BURST  2   max consecutive grants to one requester while its lock is high (>=1)
//
// PORTS
//   clk      in   1            clock, all state updates on rising edge
//   rst      in   1            synchronous active-high reset
//   req      in   NREQ         per-requester write request, level
//   lock     in   NREQ         per-requester burst request (meaningful only with req)
//   reqData  in   NREQ*WIDTH   write data; requester i owns bits [i*WIDTH +: WIDTH]
//   gnt      out  NREQ         registered one-hot grant; at most one bit high
//   writeEn  out  1            to register writeEn; = |(gnt & req)
//   inData   out  WIDTH        to register inData; reqData slice of granted requester, else 0
//
// BEHAVIOUR
//   - Reset (rst=1 at edge): gnt=0, ptr=0, last=0, burstCnt=0. writeEn=0 and inData=0
//     combinationally from gnt=0. rst dominates all other inputs.
//   - State: ptr (log2 NREQ, next-priority index), last (index of current grant),
//     burstCnt (consecutive grants to last, saturates at MAX_BURST).
//   - Eligible set each cycle: elig = req, except bit 'last' is cleared when
//     gnt[last]=1 && !(lock[last] && burstCnt < MAX_BURST).
//   - Winner: first set bit of elig searching ptr, ptr+1, ... wrapping mod NREQ.
//   - Latency: req sampled at edge t -> gnt high during cycle t+1. Each grant lasts
//     exactly one cycle and is re-evaluated every cycle. Back-to-back grants to
//     different requesters are allowed (full throughput, one write/cycle).
//   - On grant to winner w:
//     - gnt <= onehot(w); ptr <= (w+1) mod NREQ.
//     - burstCnt <= (gnt[w] ? sat(burstCnt+1) : 1); last <= w.
//   - No eligible request: gnt <= 0, burstCnt <= 0, and ptr and last are held.
//   - Handshake: requester holds req and reqData stable until it sees gnt[i].
//     The write occurs in the gnt cycle. The requester drops req in the same cycle
//     or the next one. If req[i] is low during gnt[i], writeEn=0 and that write is
//     cancelled; the grant is consumed and ptr still advances.
//   - Lock:
//     - A locked requester keeps priority for up to MAX_BURST consecutive grants,
//       then is masked for one arbitration.
//     - Lock dropped mid-burst masks it at the next arbitration.
//   - Wrap-around: ptr=NREQ-1 and grant to NREQ-1 -> ptr=0.
//   - Reset mid-grant: a gnt active in the rst cycle still drives writeEn for that
//     cycle. The next cycle is idle with priority restarting at requester 0.
//   - WIDTH arithmetic: none; inData is a pure AND-OR mux of reqData by gnt.
//
// TESTING
//   1 Reset: rst=1 with req=4'b1111 -> gnt=0, writeEn=0, inData=0; first grant after rst drop is gnt=4'b0001.
//   2 Single req: req=4'b0100, reqData[11:8]=4'hA at t -> t+1 gnt=4'b0100, writeEn=1, inData=4'hA; drop req -> gnt=0 at t+2.
//   3 Round-robin: req=4'b1111 held, lock=0 -> gnt sequence 0001,0010,0100,1000,0001; one write per cycle.
//   4 Burst: req=4'b0011, lock=4'b0001, MAX_BURST=2 -> gnt 0001,0001,0010,0001,0001,0010.
//   5 Cancel: gnt[2]=1 while req[2] dropped -> writeEn=0, inData=reqData slice, ptr advances to 3.
//   6 Wrap and reset mid-op: grant to 3 -> ptr=0; assert rst during gnt=4'b1000 -> writeEn=1 that cycle, then gnt=0, ptr=0.

Source files
------------

// File: rtl/reg_wr_arbiter.sv
// Round-robin write-port arbiter for a shared enable-gated register.
// Registered one-hot grant with optional bounded burst priority per requester.
module reg_wr_arbiter #(
   parameter int NREQ      = 4,
   parameter int WIDTH     = 4,
   parameter int MAX_BURST = 2
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic [NREQ-1:0]         req,
   input  logic [NREQ-1:0]         lock,
   input  logic [NREQ*WIDTH-1:0]   reqData,
   output logic [NREQ-1:0]         gnt,
   output logic                    writeEn,
   output logic [WIDTH-1:0]        inData
);

   localparam int PW = (NREQ > 1) ? $clog2(NREQ) : 1;
   localparam int CW = $clog2(MAX_BURST + 1);

   logic [PW-1:0]   ptr;
   logic [PW-1:0]   last;
   logic [CW-1:0]   burstCnt;
   logic [NREQ-1:0] elig;
   logic            burstOk;
   logic            holdBurst;
   logic            found;
   logic [PW-1:0]   winner;
   int              idx;

   function automatic logic [CW-1:0] satInc(input logic [CW-1:0] c);
      return (c >= CW'(MAX_BURST)) ? c : c + 1'b1;
   endfunction

   always_comb begin
      burstOk   = lock[last] && (burstCnt < CW'(MAX_BURST));
      holdBurst = gnt[last] && burstOk && req[last];
      elig      = req;
      found     = 1'b0;
      winner    = ptr;
      idx       = 0;
      // The requester just served loses its turn unless it is still within a locked burst.
      if (gnt[last] && !burstOk)
         elig[last] = 1'b0;
      if (holdBurst) begin
         found  = 1'b1;
         winner = last;
      end else begin
         for (int k = 0; k < NREQ; k++) begin
            idx = int'(ptr) + k;
            if (idx >= NREQ)
               idx = idx - NREQ;
            if (!found && elig[idx[PW-1:0]]) begin
               found  = 1'b1;
               winner = idx[PW-1:0];
            end
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         gnt      <= '0;
         ptr      <= '0;
         last     <= '0;
         burstCnt <= '0;
      end else if (found) begin
         gnt      <= NREQ'(1) << winner;
         ptr      <= (winner == PW'(NREQ - 1)) ? '0 : winner + 1'b1;
         burstCnt <= gnt[winner] ? satInc(burstCnt) : CW'(1);
         last     <= winner;
      end else begin
         gnt      <= '0;
         burstCnt <= '0;
      end
   end

   // A cancelled grant (req low) still steers inData but never writes.
   assign writeEn = |(gnt & req);

   always_comb begin
      inData = '0;
      for (int i = 0; i < NREQ; i++)
         inData = inData | (reqData[i*WIDTH +: WIDTH] & {WIDTH{gnt[i]}});
   end

endmodule

// File: tb/tb_reg_wr_arbiter.sv
// Bench for reg_wr_arbiter: directed scenarios followed by random traffic,
// all checked against an index-level round-robin reference model.
module tb_reg_wr_arbiter;

   localparam int N    = 4;
   localparam int W    = 4;
   localparam int MAXB = 2;

   logic           clk = 1'b0;
   logic           rst;
   logic [N-1:0]   req;
   logic [N-1:0]   lock;
   logic [N*W-1:0] reqData;
   logic [N-1:0]   gnt;
   logic           writeEn;
   logic [W-1:0]   inData;

   int vectors    = 0;
   int miscompares = 0;

   // Reference model state: granted index (-1 none), next-priority index, last winner, burst length.
   int mG, mPtr, mLast, mCnt;

   reg_wr_arbiter #(.NREQ(N), .WIDTH(W), .MAX_BURST(MAXB)) dut (
      .clk(clk), .rst(rst), .req(req), .lock(lock), .reqData(reqData),
      .gnt(gnt), .writeEn(writeEn), .inData(inData)
   );

   always #5 clk = ~clk;

   task automatic modelStep(input logic r, input logic [N-1:0] rq, input logic [N-1:0] lk);
      int  w;
      bit  held, keep;
      if (r) begin
         mG = -1; mPtr = 0; mLast = 0; mCnt = 0;
         return;
      end
      held = (mG == mLast);
      keep = held && lk[mLast] && (mCnt < MAXB);
      w = -1;
      if (keep && rq[mLast])
         w = mLast;
      else
         for (int k = 0; k < N; k++) begin
            int i;
            i = (mPtr + k) % N;
            if (w < 0 && rq[i] && !(i == mLast && held && !keep))
               w = i;
         end
      if (w >= 0) begin
         mCnt  = (mG == w) ? ((mCnt + 1 > MAXB) ? MAXB : mCnt + 1) : 1;
         mG    = w;
         mLast = w;
         mPtr  = (w + 1) % N;
      end else begin
         mG   = -1;
         mCnt = 0;
      end
   endtask

   // One clock: drive inputs, check outputs of the current grant, advance the model.
   // expG[4]=0 adds a check of gnt against the literal expG[3:0].
   task automatic cycle(input logic r, input logic [N-1:0] rq, input logic [N-1:0] lk,
                        input logic [N*W-1:0] d, input logic [4:0] expG);
      logic [N-1:0] eGnt;
      logic         eWe;
      logic [W-1:0] eData;
      @(negedge clk);
      rst = r; req = rq; lock = lk; reqData = d;
      #1;
      eGnt  = (mG < 0) ? '0 : N'(1) << mG;
      eWe   = (mG >= 0) && rq[mG];
      eData = (mG < 0) ? '0 : d[mG*W +: W];
      vectors++;
      assert (gnt === eGnt) else begin
         miscompares++;
         $error("FAIL gnt: observed %b expected %b", gnt, eGnt);
      end
      vectors++;
      assert (writeEn === eWe) else begin
         miscompares++;
         $error("FAIL writeEn: observed %b expected %b", writeEn, eWe);
      end
      vectors++;
      assert (inData === eData) else begin
         miscompares++;
         $error("FAIL inData: observed %h expected %h", inData, eData);
      end
      if (!expG[4]) begin
         vectors++;
         assert (gnt === expG[N-1:0]) else begin
            miscompares++;
            $error("FAIL gntSeq: observed %b expected %b", gnt, expG[N-1:0]);
         end
      end
      modelStep(r, rq, lk);
   endtask

   initial begin
      rst = 1'b1; req = '0; lock = '0; reqData = '0;
      repeat (2) @(negedge clk);
      modelStep(1'b1, '0, '0);

      // Reset holds off all requesters; first grant afterwards goes to requester 0.
      cycle(1, 4'b1111, 4'b0000, 16'h4321, 5'b0_0000);
      cycle(0, 4'b1111, 4'b0000, 16'h4321, 5'b0_0000);
      cycle(0, 4'b0000, 4'b0000, 16'h4321, 5'b0_0001);

      // Single requester 2 with data A.
      cycle(0, 4'b0100, 4'b0000, 16'h0A00, 5'b0_0000);
      cycle(0, 4'b0100, 4'b0000, 16'h0A00, 5'b0_0100);
      cycle(0, 4'b0000, 4'b0000, 16'h0A00, 5'b0_0000);

      // Plain round robin with wrap from 3 back to 0.
      cycle(1, 4'b0000, 4'b0000, 16'h0000, 5'b1_0000);
      cycle(0, 4'b1111, 4'b0000, 16'hDCBA, 5'b0_0000);
      cycle(0, 4'b1111, 4'b0000, 16'hDCBA, 5'b0_0001);
      cycle(0, 4'b1111, 4'b0000, 16'hDCBA, 5'b0_0010);
      cycle(0, 4'b1111, 4'b0000, 16'hDCBA, 5'b0_0100);
      cycle(0, 4'b1111, 4'b0000, 16'hDCBA, 5'b0_1000);
      cycle(0, 4'b1111, 4'b0000, 16'hDCBA, 5'b0_0001);

      // Locked burst of two for requester 0 against requester 1.
      cycle(1, 4'b0000, 4'b0000, 16'h0000, 5'b1_0000);
      cycle(0, 4'b0011, 4'b0001, 16'h0096, 5'b0_0000);
      cycle(0, 4'b0011, 4'b0001, 16'h0096, 5'b0_0001);
      cycle(0, 4'b0011, 4'b0001, 16'h0096, 5'b0_0001);
      cycle(0, 4'b0011, 4'b0001, 16'h0096, 5'b0_0010);
      cycle(0, 4'b0011, 4'b0001, 16'h0096, 5'b0_0001);
      cycle(0, 4'b0011, 4'b0001, 16'h0096, 5'b0_0001);
      cycle(0, 4'b0011, 4'b0001, 16'h0096, 5'b0_0010);

      // Cancelled grant to 2 still advances priority to 3; reset lands during that grant.
      cycle(1, 4'b0000, 4'b0000, 16'h0000, 5'b1_0000);
      cycle(0, 4'b0100, 4'b0000, 16'h7500, 5'b0_0000);
      cycle(0, 4'b0000, 4'b0000, 16'h7500, 5'b0_0100);
      cycle(0, 4'b1111, 4'b0000, 16'hE500, 5'b0_0000);
      cycle(1, 4'b1000, 4'b0000, 16'hE500, 5'b0_1000);
      cycle(0, 4'b1111, 4'b0000, 16'h1234, 5'b0_0000);
      cycle(0, 4'b1111, 4'b0000, 16'h1234, 5'b0_0001);

      // Random traffic with occasional reset.
      for (int n = 0; n < 600; n++) begin
         logic          r;
         logic [N-1:0]  rq, lk;
         logic [N*W-1:0] d;
         r  = ($urandom_range(0, 49) == 0);
         rq = N'($urandom);
         lk = N'($urandom);
         d  = (N*W)'($urandom);
         cycle(r, rq, lk, d, 5'b1_0000);
      end

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
